// File: rtl/uart_fifo_peri_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_fifo_peri_if : CPU bus + uart core handshake bundle          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart_fifo_peri_if;
  logic [31:0] rdaddress;
  logic        rden;
  logic [31:0] rdata;
  logic [31:0] wraddress;
  logic [31:0] wdata;
  logic [3:0]  wrbyteena;
  logic        wren;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ack;
  logic [7:0]  rx_data;
  logic        rx_data_fresh;
  logic        uart_intr;

  modport master (
    output rdaddress, rden, wraddress, wdata, wrbyteena, wren,
    output tx_data_ack, rx_data, rx_data_fresh,
    input  rdata, tx_data, tx_data_valid, uart_intr
  );

  modport slave (
    input  rdaddress, rden, wraddress, wdata, wrbyteena, wren,
    input  tx_data_ack, rx_data, rx_data_fresh,
    output rdata, tx_data, tx_data_valid, uart_intr
  );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_peri.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_fifo_peri : memory-mapped UART front end with RX/TX FIFOs,   |
// |                  status/IER registers and a level interrupt       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_fifo_peri #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h20000,
  parameter int          RX_THRESH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  uart_fifo_peri_if.slave     bus
);
  localparam int          c_aw  = $clog2(DEPTH);
  localparam int          c_cw  = c_aw + 1;
  localparam logic [31:0] c_dr  = BASE_ADDR;
  localparam logic [31:0] c_sr  = BASE_ADDR + 32'd4;
  localparam logic [31:0] c_ier = BASE_ADDR + 32'd8;
  localparam logic [0:0]  c_st_idle = 1'b0;
  localparam logic [0:0]  c_st_send = 1'b1;

  logic [7:0]      r_rx_mem [DEPTH];
  logic [7:0]      r_tx_mem [DEPTH];
  logic [c_aw-1:0] r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;
  logic [c_cw-1:0] r_rx_cnt, r_tx_cnt;
  logic            r_rx_overrun, r_tx_drop, r_intr;
  logic [3:0]      r_ier;
  logic [0:0]      r_state, w_state_nxt;

  logic w_rd_dr, w_rd_sr, w_rd_ier, w_wr_dr, w_wr_sr, w_wr_ier;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_rx_thresh;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_ovr_set, w_drop_set;
  logic w_tx_busy;
  logic [7:0]  w_tx_data;
  logic [31:0] w_sr;
  logic        w_unused;

  assign w_unused = ^{bus.wdata[31:8], bus.wrbyteena[3:1]};

  assign w_rd_dr  = bus.rden && (bus.rdaddress == c_dr);
  assign w_rd_sr  = bus.rden && (bus.rdaddress == c_sr);
  assign w_rd_ier = bus.rden && (bus.rdaddress == c_ier);
  assign w_wr_dr  = bus.wren && bus.wrbyteena[0] && (bus.wraddress == c_dr);
  assign w_wr_sr  = bus.wren && bus.wrbyteena[0] && (bus.wraddress == c_sr);
  assign w_wr_ier = bus.wren && bus.wrbyteena[0] && (bus.wraddress == c_ier);

  assign w_rx_empty  = (r_rx_cnt == '0);
  assign w_rx_full   = (r_rx_cnt == c_cw'(DEPTH));
  assign w_tx_empty  = (r_tx_cnt == '0);
  assign w_tx_full   = (r_tx_cnt == c_cw'(DEPTH));
  assign w_rx_thresh = (r_rx_cnt >= c_cw'(RX_THRESH));

  // A full RX still accepts a byte when a DR read frees a slot in the same cycle.
  assign w_rx_pop   = w_rd_dr && !w_rx_empty;
  assign w_rx_push  = bus.rx_data_fresh && (!w_rx_full || w_rx_pop);
  assign w_ovr_set  = bus.rx_data_fresh && w_rx_full && !w_rx_pop;
  assign w_tx_push  = w_wr_dr && !w_tx_full;
  assign w_drop_set = w_wr_dr && w_tx_full;
  assign w_tx_pop   = (r_state == c_st_send) && bus.tx_data_ack;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= bus.rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_aw'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_aw'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + c_cw'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - c_cw'(1);
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_aw'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_aw'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + c_cw'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - c_cw'(1);
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_overrun <= 1'b0;
      r_tx_drop    <= 1'b0;
      r_ier        <= '0;
      r_intr       <= 1'b0;
    end else begin
      if (w_ovr_set)                         r_rx_overrun <= 1'b1;
      else if (w_wr_sr && bus.wdata[4])      r_rx_overrun <= 1'b0;
      if (w_drop_set)                        r_tx_drop    <= 1'b1;
      else if (w_wr_sr && bus.wdata[6])      r_tx_drop    <= 1'b0;
      if (w_wr_ier) r_ier <= bus.wdata[3:0];
      r_intr <= |(r_ier & {w_rx_thresh, (r_rx_overrun | r_tx_drop),
                           w_tx_empty, !w_rx_empty});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (!w_tx_empty)      w_state_nxt = c_st_send;
      c_st_send: if (bus.tx_data_ack)  w_state_nxt = c_st_idle;
      default:                         w_state_nxt = c_st_idle;
    endcase
  end

  // The head cannot move while in SEND, so the offered byte stays stable.
  always_comb begin
    w_tx_busy = 1'b0;
    w_tx_data = 8'h00;
    if (r_state == c_st_send) begin
      w_tx_busy = 1'b1;
      w_tx_data = r_tx_mem[r_tx_rd];
    end
  end

  assign bus.tx_data       = w_tx_data;
  assign bus.tx_data_valid = w_tx_busy;
  assign bus.uart_intr     = r_intr;

  assign w_sr = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt),
                 w_rx_thresh, r_tx_drop, w_tx_busy, r_rx_overrun,
                 w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};

  always_comb begin
    bus.rdata = 32'h0;
    if (w_rd_dr)       bus.rdata = {24'h0, w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd]};
    else if (w_rd_sr)  bus.rdata = w_sr;
    else if (w_rd_ier) bus.rdata = {28'h0, r_ier};
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_peri.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_fifo_peri : directed self-checking bench for uart_fifo_peri |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_fifo_peri;
  localparam logic [31:0] c_dr  = 32'h20000;
  localparam logic [31:0] c_sr  = 32'h20004;
  localparam logic [31:0] c_ier = 32'h20008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  uart_fifo_peri_if bus ();

  uart_fifo_peri #(.DEPTH(16), .BASE_ADDR(32'h20000), .RX_THRESH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.rdaddress = addr;
    bus.rden      = 1'b1;
    #1 data = bus.rdata;
    @(negedge clk);
    bus.rden = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    bus.wraddress = addr;
    bus.wdata     = data;
    bus.wrbyteena = be;
    bus.wren      = 1'b1;
    @(negedge clk);
    bus.wren = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data       = b;
    bus.rx_data_fresh = 1'b1;
    @(negedge clk);
    bus.rx_data_fresh = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.tx_data_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait", {31'h0, bus.tx_data_valid}, 32'h1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  tx_exp [3];
    tx_exp[0] = 8'h41; tx_exp[1] = 8'h42; tx_exp[2] = 8'h43;
    bus.rdaddress = '0; bus.rden = 1'b0; bus.wraddress = '0; bus.wdata = '0;
    bus.wrbyteena = '0; bus.wren = 1'b0; bus.tx_data_ack = 1'b0;
    bus.rx_data = '0; bus.rx_data_fresh = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_read(c_sr, d);
    check("reset_sr", d, 32'h0000_0004);
    check("reset_intr", {31'h0, bus.uart_intr}, 32'h0);
    check("reset_valid", {31'h0, bus.tx_data_valid}, 32'h0);
    check("reset_txdata", {24'h0, bus.tx_data}, 32'h0);

    // TX path: three bytes, each acknowledged after 10 cycles
    for (int i = 0; i < 3; i++) bus_write(c_dr, {24'h0, tx_exp[i]}, 4'b0001);
    bus_read(c_sr, d);
    check("sr_tx_busy", d, 32'h0003_0020);
    for (int k = 0; k < 3; k++) begin
      wait_valid();
      check("tx_data", {24'h0, bus.tx_data}, {24'h0, tx_exp[k]});
      repeat (10) @(negedge clk);
      check("tx_hold_valid", {31'h0, bus.tx_data_valid}, 32'h1);
      check("tx_hold_data", {24'h0, bus.tx_data}, {24'h0, tx_exp[k]});
      bus.tx_data_ack = 1'b1;
      @(negedge clk);
      bus.tx_data_ack = 1'b0;
      check("tx_valid_drop", {31'h0, bus.tx_data_valid}, 32'h0);
    end
    bus_read(c_sr, d);
    check("sr_tx_done", d, 32'h0000_0004);

    // RX overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) rx_byte(8'(i));
    bus_read(c_sr, d);
    check("sr_rx_overrun", d, 32'h0000_1097);
    for (int i = 0; i < 16; i++) begin
      bus_read(c_dr, d);
      check("rx_dr", d, 32'(i));
    end
    bus_read(c_dr, d);
    check("rx_empty_dr", d, 32'h0);
    bus_read(c_sr, d);
    check("sr_rx_drained", d, 32'h0000_0014);
    bus_write(c_sr, 32'h10, 4'b0001);
    bus_read(c_sr, d);
    check("sr_w1c_ovr", d, 32'h0000_0004);

    // Full RX with a coincident DR read and push
    for (int i = 0; i < 16; i++) rx_byte(8'hA0 + 8'(i));
    @(negedge clk);
    bus.rdaddress = c_dr; bus.rden = 1'b1;
    bus.rx_data = 8'h55; bus.rx_data_fresh = 1'b1;
    #1 check("coinc_dr", bus.rdata, 32'hA0);
    @(negedge clk);
    bus.rden = 1'b0; bus.rx_data_fresh = 1'b0;
    bus_read(c_sr, d);
    check("sr_coinc", d, 32'h0000_1087);
    for (int i = 1; i < 16; i++) begin
      bus_read(c_dr, d);
      check("coinc_drain", d, 32'hA0 + 32'(i));
    end
    bus_read(c_dr, d);
    check("coinc_last", d, 32'h55);

    // Threshold interrupt
    bus_write(c_ier, 32'h8, 4'b0001);
    bus_read(c_ier, d);
    check("ier_rd", d, 32'h8);
    for (int i = 0; i < 3; i++) rx_byte(8'h10 + 8'(i));
    @(negedge clk);
    check("thr_below", {31'h0, bus.uart_intr}, 32'h0);
    rx_byte(8'h13);
    check("thr_lat0", {31'h0, bus.uart_intr}, 32'h0);
    @(negedge clk);
    check("thr_raise", {31'h0, bus.uart_intr}, 32'h1);
    bus_read(c_dr, d);
    check("thr_pop_dr", d, 32'h10);
    check("thr_hold", {31'h0, bus.uart_intr}, 32'h1);
    @(negedge clk);
    check("thr_drop", {31'h0, bus.uart_intr}, 32'h0);
    for (int i = 0; i < 3; i++) bus_read(c_dr, d);

    // Error interrupt and W1C byte-enable gating
    bus_write(c_ier, 32'h4, 4'b0001);
    for (int i = 0; i < 17; i++) rx_byte(8'(i));
    @(negedge clk);
    check("err_intr", {31'h0, bus.uart_intr}, 32'h1);
    bus_write(c_sr, 32'h10, 4'b0000);
    bus_read(c_sr, d);
    check("sr_be0_kept", d, 32'h0000_1097);
    check("err_intr_kept", {31'h0, bus.uart_intr}, 32'h1);
    bus_write(c_sr, 32'h10, 4'b0001);
    check("err_intr_lat", {31'h0, bus.uart_intr}, 32'h1);
    @(negedge clk);
    check("err_intr_clr", {31'h0, bus.uart_intr}, 32'h0);
    for (int i = 0; i < 16; i++) bus_read(c_dr, d);
    bus_write(c_ier, 32'h0, 4'b0001);

    // TX drop: first byte sits unacknowledged, 16 fill the FIFO, 17th drops
    for (int i = 0; i < 17; i++) bus_write(c_dr, 32'h60 + 32'(i), 4'b0001);
    bus_read(c_sr, d);
    check("sr_tx_drop", d, 32'h0010_0068);
    check("drop_head", {24'h0, bus.tx_data}, 32'h60);
    bus_write(c_sr, 32'h40, 4'b0001);
    bus_read(c_sr, d);
    check("sr_w1c_drop", d, 32'h0010_0028);

    // Asynchronous reset mid-transfer
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_valid", {31'h0, bus.tx_data_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(c_sr, d);
    check("rst_sr", d, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_fifo_peri.md
Name: uart_fifo_peri

Overview:
- Memory-mapped UART front end that puts parametrised RX and TX FIFOs between the CPU data bus and the uart core.
- Provides data, status and interrupt-enable registers, sticky error flags and a registered, level-sensitive maskable interrupt.
- Sits in the peripherals block at the UART base address. Drives the uart core's tx_data/tx_data_valid/tx_data_ack/rx_data/rx_data_fresh handshake on the same clock.

Parameters:
- DEPTH, 16, entries per FIFO; power of two, 2..128.
- BASE_ADDR, 32'h20000, byte address of DR; SR = BASE+4, IER = BASE+8.
- RX_THRESH, 4, RX level (1..DEPTH) at which the threshold status bit asserts.

Ports:
- clk  in  1  system clock; uart core runs on the same clock.
- rst  in  1  asynchronous, active-high reset.
- rdaddress  in  32  bus read address.
- rden  in  1  bus read strobe, single cycle.
- rdata  out  32  read data, combinational; 0 when no register is selected.
- wraddress  in  32  bus write address.
- wdata  in  32  write data.
- wrbyteena  in  4  byte enables; only lane 0 is used.
- wren  in  1  bus write strobe, single cycle.
- tx_data  out  8  byte to uart core.
- tx_data_valid  out  1  byte offered; held until acknowledged.
- tx_data_ack  in  1  one-cycle pulse from core: byte accepted and transmitted.
- rx_data  in  8  received byte.
- rx_data_fresh  in  1  one-cycle pulse: rx_data valid.
- uart_intr  out  1  level interrupt, registered.

Behaviour:
- Reset (async, rst=1):
  - Both FIFOs empty, pointers and counts 0.
  - SR sticky bits 0, IER 0, TX FSM in IDLE.
  - tx_data_valid=0, tx_data=0, uart_intr=0.
- Register selection:
  - Write hits only when wren & wrbyteena[0] & wraddress matches.
  - Read hits only when rden & rdaddress matches.
  - A write with wrbyteena[0]=0 has no effect.
- DR read:
  - rdata = {24'h0, RX head} in the same cycle.
  - RX pops at the following clock edge if the FIFO is not empty.
  - Reading an empty RX returns 0 with no pointer change.
- DR write:
  - Pushes wdata[7:0] into TX.
  - A write to a full TX is dropped and sets SR.tx_drop.
- RX push: on rx_data_fresh, rx_data is pushed.
  - If full and there is no same-cycle pop, the byte is dropped, SR.rx_overrun sets, and FIFO contents are unchanged.
  - If full with a same-cycle DR read, the pop and push both occur and the count stays DEPTH with no overrun.
- SR read fields:
  - [0] rx_avail (count>0)
  - [1] rx_full
  - [2] tx_empty
  - [3] tx_full
  - [4] rx_overrun (sticky)
  - [5] tx_busy (FSM in SEND)
  - [6] tx_drop (sticky)
  - [7] rx_thresh (rx_count >= RX_THRESH)
  - [15:8] rx_count (zero-extended)
  - [23:16] tx_count
  - [31:24] 0
- SR write: W1C on bits [4] and [6]; all other bits ignored. If set and clear coincide, set wins.
- IER: R/W [3:0] = enables for rx_avail, tx_empty, error (rx_overrun|tx_drop), rx_thresh; [31:4] read 0.
- Interrupt:
  - uart_intr <= |(enabled sources), registered, so one cycle after the source changes.
  - It stays high until the source clears; no edge latching.
- TX FSM:
  - IDLE: if TX is not empty, drive tx_data = head and tx_data_valid=1, then go to SEND. Entry takes one cycle after the push.
  - SEND: hold tx_data/valid stable. On tx_data_ack, pop TX, drop valid and return to IDLE.
  - Back-to-back bytes therefore have one IDLE cycle between valid windows.
- FIFO arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - A DR write to an empty TX while the FSM is IDLE is not bypassed; it goes through the FIFO.
- Reset mid-transfer: valid drops immediately (async); any queued bytes are lost.

Test Plan:
- Reset, then read SR → 32'h0000_0004 (tx_empty only). uart_intr=0, tx_data_valid=0.
- Write DR 0x41, 0x42, 0x43; ack each after 10 cycles → tx_data = 0x41, 0x42, 0x43 in order. valid held until ack. After the last ack, SR[2]=1 and SR[23:16]=0.
- Pulse rx_data_fresh 17 times (DEPTH=16, bytes 0x00..0x10) → SR[1]=1, SR[4]=1, rx_count=16. DR reads return 0x00..0x0F, then 0 on the empty read.
- Full RX plus a DR read coinciding with rx_data_fresh (0x55) → no overrun, count stays 16, and 0x55 is read last.
- IER=4'b1000 with RX_THRESH=4: the 4th RX byte raises uart_intr 1 cycle later. One DR read drops it 1 cycle after the pop.
- Set rx_overrun with IER[2]=1, then write SR 0x10 → bit clears and uart_intr deasserts the following cycle. Writing SR with wrbyteena=4'b0000 leaves it set.
